// File: rtl/double_peak_hold.sv
// double_peak_hold: two-stage magnitude peak detector over windows of WINDOW valid IEEE-754 doubles.
module double_peak_hold #(
  parameter int WINDOW = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] in_a,
  input  logic        in_a_stb,
  input  logic        clear,
  output logic [63:0] peak_z,
  output logic        peak_z_stb,
  output logic        nan_seen,
  output logic [15:0] window_count
);
  logic [62:0] s1_mag_q, s1_mag_d, max_q, max_d, max_nxt;
  logic        s1_vld_q, s1_vld_d, s1_nan_q, s1_nan_d;
  logic [15:0] cnt_q, cnt_d;
  logic [63:0] peak_q, peak_d;
  logic        stb_q, stb_d, nan_q, nan_d, last;
  always_comb begin
    s1_mag_d = in_a[62:0];
    s1_vld_d = in_a_stb & ~clear;
    s1_nan_d = (&in_a[62:52]) & (|in_a[51:0]);
    max_nxt  = (s1_vld_q && !s1_nan_q && s1_mag_q > max_q) ? s1_mag_q : max_q;
    // the window closes on the stage-2 edge that sees its WINDOW-th valid sample
    last     = s1_vld_q && ({1'b0, cnt_q} + 17'd1 == 17'(WINDOW));
    max_d    = (clear || last) ? 63'd0 : max_nxt;
    cnt_d    = (clear || last) ? 16'd0 : cnt_q + {15'd0, s1_vld_q};
    peak_d   = (last && !clear) ? {1'b0, max_nxt} : peak_q;
    stb_d    = last & ~clear;
    nan_d    = ~clear & (nan_q | (s1_vld_q & s1_nan_q));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_mag_q <= '0;
      s1_vld_q <= 1'b0;
      s1_nan_q <= 1'b0;
      max_q    <= '0;
      cnt_q    <= '0;
      peak_q   <= '0;
      stb_q    <= 1'b0;
      nan_q    <= 1'b0;
    end else begin
      s1_mag_q <= s1_mag_d;
      s1_vld_q <= s1_vld_d;
      s1_nan_q <= s1_nan_d;
      max_q    <= max_d;
      cnt_q    <= cnt_d;
      peak_q   <= peak_d;
      stb_q    <= stb_d;
      nan_q    <= nan_d;
    end
  end
  assign peak_z       = peak_q;
  assign peak_z_stb   = stb_q;
  assign nan_seen     = nan_q;
  assign window_count = cnt_q;
endmodule
